// File: rtl/step_pkg.sv
// Shared types, phase table and step helper for the multi-axis stepper controller.
package step_pkg;

    localparam int unsigned PHASE_W = 3;

    typedef logic [PHASE_W-1:0] phase_t;
    typedef logic [3:0]         coil_t;

    // Index 1 is the first two-coil pattern; full-step mode walks the odd entries.
    localparam phase_t PHASE_IDX_RESET = phase_t'(1);

    localparam coil_t PHASE_TABLE [8] = '{
        4'b1000, 4'b1100, 4'b0100, 4'b0110,
        4'b0010, 4'b0011, 4'b0001, 4'b1001
    };

    // Full-step from an even (one-coil) index moves by 1 to land back on a two-coil pattern.
    function automatic phase_t next_phase(input phase_t idx, input logic fwd, input logic half);
        phase_t delta;
        delta = (half || !idx[0]) ? phase_t'(1) : phase_t'(2);
        return fwd ? phase_t'(idx + delta) : phase_t'(idx - delta);
    endfunction

endpackage

// File: rtl/step_debounce.sv
// Single-bit debouncer: output follows input after DB_CYCLES consecutive cycles of a new value.
module step_debounce #(
    parameter int unsigned DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int unsigned      CNT_W    = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            dout <= 1'b0;
        end else if (din == dout) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt  <= '0;
            dout <= din;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/multi_axis_step_ctrl.sv
// N-axis unipolar stepper controller: debounced controls, shared step-rate divider,
// per-axis phase sequencing, limit inhibit and home-referenced position tracking.
module multi_axis_step_ctrl
    import step_pkg::*;
#(
    parameter int unsigned N_AXES    = 2,
    parameter int unsigned DIV_W     = 24,
    parameter int unsigned DB_CYCLES = 1000000,
    parameter int unsigned POS_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_AXES-1:0]       dir,
    input  logic [N_AXES-1:0]       en,
    input  logic [N_AXES-1:0]       lim_min,
    input  logic [N_AXES-1:0]       lim_max,
    input  logic                    half_step,
    input  logic [DIV_W-1:0]        step_div,
    output logic [4*N_AXES-1:0]     coil_out,
    output logic [POS_W*N_AXES-1:0] position,
    output logic [N_AXES-1:0]       limit_hit,
    output logic                    tick
);

    logic [4*N_AXES-1:0] raw_in;
    logic [4*N_AXES-1:0] db_out;
    logic [N_AXES-1:0]   dir_db;
    logic [N_AXES-1:0]   en_db;
    logic [N_AXES-1:0]   min_db;
    logic [N_AXES-1:0]   max_db;

    assign raw_in = {lim_max, lim_min, en, dir};

    for (genvar i = 0; i < 4 * N_AXES; i++) begin : g_db
        step_debounce #(
            .DB_CYCLES(DB_CYCLES)
        ) u_db (
            .clk (clk),
            .rst (rst),
            .din (raw_in[i]),
            .dout(db_out[i])
        );
    end

    assign dir_db = db_out[N_AXES-1:0];
    assign en_db  = db_out[2*N_AXES-1:N_AXES];
    assign min_db = db_out[3*N_AXES-1:2*N_AXES];
    assign max_db = db_out[4*N_AXES-1:3*N_AXES];

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_last;

    // A zero divisor behaves as 1, i.e. a tick every cycle.
    always_comb begin
        div_last = (step_div == '0) ? '0 : step_div - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else if (div_cnt >= div_last) begin
            div_cnt <= '0;
            tick    <= 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
            tick    <= 1'b0;
        end
    end

    for (genvar k = 0; k < N_AXES; k++) begin : g_axis
        phase_t           idx;
        phase_t           idx_nxt;
        coil_t            coil_q;
        logic [POS_W-1:0] pos_q;
        logic             hit_q;
        logic             inhibit;
        logic             do_step;

        always_comb begin
            inhibit = dir_db[k] ? max_db[k] : min_db[k];
            do_step = tick && en_db[k] && !inhibit;
            idx_nxt = do_step ? next_phase(idx, dir_db[k], half_step) : idx;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                idx    <= PHASE_IDX_RESET;
                coil_q <= '0;
                pos_q  <= '0;
                hit_q  <= 1'b0;
            end else begin
                idx    <= idx_nxt;
                coil_q <= en_db[k] ? PHASE_TABLE[idx_nxt] : '0;
                // Home switch wins over any step taken in the same cycle.
                if (min_db[k]) begin
                    pos_q <= '0;
                end else if (do_step) begin
                    pos_q <= dir_db[k] ? pos_q + 1'b1 : pos_q - 1'b1;
                end
                if (!en_db[k]) begin
                    hit_q <= 1'b0;
                end else if (tick && inhibit) begin
                    hit_q <= 1'b1;
                end
            end
        end

        assign coil_out[4*k +: 4]         = coil_q;
        assign position[POS_W*k +: POS_W] = pos_q;
        assign limit_hit[k]               = hit_q;
    end

endmodule

// File: tb/tb_multi_axis_step_ctrl.sv
// Directed self-checking bench for multi_axis_step_ctrl (2 axes, DB_CYCLES=4).
module tb_multi_axis_step_ctrl;

    localparam int unsigned N_AXES = 2;
    localparam int unsigned DIV_W  = 24;
    localparam int unsigned POS_W  = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N_AXES-1:0]       dir;
    logic [N_AXES-1:0]       en;
    logic [N_AXES-1:0]       lim_min;
    logic [N_AXES-1:0]       lim_max;
    logic                    half_step;
    logic [DIV_W-1:0]        step_div;
    logic [4*N_AXES-1:0]     coil_out;
    logic [POS_W*N_AXES-1:0] position;
    logic [N_AXES-1:0]       limit_hit;
    logic                    tick;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    multi_axis_step_ctrl #(
        .N_AXES   (N_AXES),
        .DIV_W    (DIV_W),
        .DB_CYCLES(4),
        .POS_W    (POS_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .dir      (dir),
        .en       (en),
        .lim_min  (lim_min),
        .lim_max  (lim_max),
        .half_step(half_step),
        .step_div (step_div),
        .coil_out (coil_out),
        .position (position),
        .limit_hit(limit_hit),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Waits for a tick, then one more cycle so the step is visible; returns cycles spent.
    task automatic wait_step(input string tag, output int unsigned cycles);
        logic seen;
        seen   = 1'b0;
        cycles = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            cycles++;
            seen = tick;
        end
        check({tag, "_tick_seen"}, {31'b0, seen}, 32'd1);
        @(negedge clk);
        cycles++;
    endtask

    // Slow divider keeps steps out of the debounce window after reset.
    task automatic do_reset();
        step_div = 24'd1000;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    logic [3:0]  exp_c1 [3] = '{4'b0100, 4'b0110, 4'b0010};
    logic [3:0]  exp_c2 [6] = '{4'b1001, 4'b0011, 4'b0110, 4'b1100, 4'b1000, 4'b1001};
    logic [15:0] exp_p2 [6] = '{16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC, 16'hFFFB, 16'hFFFA};

    initial begin
        int unsigned cyc;
        logic [7:0]  coil_seen;

        rst = 1'b1; dir = '0; en = '0; lim_min = '0; lim_max = '0;
        half_step = 1'b0; step_div = 24'd1000;
        @(negedge clk);
        check("rst_coil", {24'b0, coil_out}, 32'h0);
        check("rst_pos", position, 32'h0);
        check("rst_tick", {31'b0, tick}, 32'h0);
        check("rst_hit", {30'b0, limit_hit}, 32'h0);

        // 1: half-step forward on axis 0
        en = 2'b01; dir = 2'b01; half_step = 1'b1;
        do_reset();
        check("t1_coil_init", {24'b0, coil_out}, 32'h0C);
        step_div = 24'd3;
        for (int i = 0; i < 3; i++) begin
            wait_step("t1", cyc);
            if (i > 0) check("t1_period", cyc, 32'd3);
            check("t1_coil", {28'b0, coil_out[3:0]}, {28'b0, exp_c1[i]});
            check("t1_pos", {16'b0, position[15:0]}, i + 1);
        end
        check("t1_axis1_coil", {28'b0, coil_out[7:4]}, 32'h0);

        // 2: full-step reverse from idx 1, then half-step mid-run
        en = 2'b01; dir = 2'b00; half_step = 1'b0;
        do_reset();
        step_div = 24'd3;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) half_step = 1'b1;
            wait_step("t2", cyc);
            check("t2_coil", {28'b0, coil_out[3:0]}, {28'b0, exp_c2[i]});
            check("t2_pos", {16'b0, position[15:0]}, {16'b0, exp_p2[i]});
        end

        // 3: short enable pulse is filtered out
        en = 2'b00; dir = 2'b00;
        do_reset();
        step_div = 24'd3;
        coil_seen = '0;
        en = 2'b01;
        repeat (3) begin
            @(negedge clk);
            coil_seen |= coil_out;
        end
        en = 2'b00;
        repeat (10) begin
            @(negedge clk);
            coil_seen |= coil_out;
        end
        check("t3_coil_quiet", {24'b0, coil_seen}, 32'h0);

        // 4: max limit blocks forward steps; reverse still allowed, hit sticky until en drops
        en = 2'b01; dir = 2'b01; half_step = 1'b1; lim_max = 2'b01;
        do_reset();
        check("t4_hit_pre", {30'b0, limit_hit}, 32'h0);
        step_div = 24'd3;
        wait_step("t4a", cyc);
        check("t4_coil_frozen", {28'b0, coil_out[3:0]}, 32'hC);
        check("t4_pos_frozen", {16'b0, position[15:0]}, 32'h0);
        check("t4_hit_set", {30'b0, limit_hit}, 32'h1);
        step_div = 24'd1000;
        dir = 2'b00;
        repeat (6) @(negedge clk);
        step_div = 24'd3;
        wait_step("t4b", cyc);
        check("t4_coil_rev", {28'b0, coil_out[3:0]}, 32'h8);
        check("t4_pos_rev", {16'b0, position[15:0]}, 32'hFFFF);
        check("t4_hit_sticky", {30'b0, limit_hit}, 32'h1);
        en = 2'b00;
        repeat (6) @(negedge clk);
        check("t4_hit_clr", {30'b0, limit_hit}, 32'h0);
        check("t4_coil_off", {24'b0, coil_out}, 32'h0);
        lim_max = '0;

        // 5: axis 1 driven to -7 then homed by its min limit; axis 0 independent
        en = 2'b11; dir = 2'b01; half_step = 1'b1;
        do_reset();
        step_div = 24'd3;
        repeat (7) wait_step("t5", cyc);
        check("t5_pos1_neg7", {16'b0, position[31:16]}, 32'hFFF9);
        check("t5_coils", {24'b0, coil_out}, 32'h48);
        step_div = 24'd1000;
        lim_min = 2'b10;
        repeat (6) @(negedge clk);
        check("t5_pos1_home", {16'b0, position[31:16]}, 32'h0);
        check("t5_pos0_kept", {16'b0, position[15:0]}, 32'h7);
        lim_min = 2'b00; dir = 2'b11;
        repeat (6) @(negedge clk);
        step_div = 24'd3;
        wait_step("t5b", cyc);
        check("t5_pos1_fwd", {16'b0, position[31:16]}, 32'h1);
        check("t5_pos0_fwd", {16'b0, position[15:0]}, 32'h8);
        check("t5_coil_fwd", {24'b0, coil_out}, 32'h6C);

        // 6: zero divisor ticks every cycle; reset mid-run
        en = 2'b01; dir = 2'b01; half_step = 1'b1;
        do_reset();
        step_div = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t6_tick", {31'b0, tick}, 32'h1);
        end
        check("t6_pos", {16'b0, position[15:0]}, 32'h3);
        check("t6_coil", {28'b0, coil_out[3:0]}, 32'h2);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_coil", {24'b0, coil_out}, 32'h0);
        check("t6_rst_pos", position, 32'h0);
        check("t6_rst_tick", {31'b0, tick}, 32'h0);
        check("t6_rst_hit", {30'b0, limit_hit}, 32'h0);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
